// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and per-stage bundle widths for pipeline stage registers
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      IF_ID  = 2'd0,
      ID_EX  = 2'd1,
      EX_MEM = 2'd2,
      MEM_WB = 2'd3
   } stage_t;

   localparam int IF_ID_DATA_W  = 64;
   localparam int IF_ID_CTRL_W  = 1;
   localparam int ID_EX_DATA_W  = 106;
   localparam int ID_EX_CTRL_W  = 9;
   localparam int EX_MEM_DATA_W = 69;
   localparam int EX_MEM_CTRL_W = 4;
   localparam int MEM_WB_DATA_W = 69;
   localparam int MEM_WB_CTRL_W = 2;

   function automatic int stage_data_w(stage_t s);
      case (s)
         IF_ID:   return IF_ID_DATA_W;
         ID_EX:   return ID_EX_DATA_W;
         EX_MEM:  return EX_MEM_DATA_W;
         default: return MEM_WB_DATA_W;
      endcase
   endfunction

   function automatic int stage_ctrl_w(stage_t s);
      case (s)
         IF_ID:   return IF_ID_CTRL_W;
         ID_EX:   return ID_EX_CTRL_W;
         EX_MEM:  return EX_MEM_CTRL_W;
         default: return MEM_WB_CTRL_W;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - valid/ready handshake carrying a data and a control bundle
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = stage_data_w(EX_MEM),
   parameter int CTRL_W = stage_ctrl_w(EX_MEM)
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, data, ctrl, input ready);
   modport slave  (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+data+ctrl holding register with load and clear
module pipe_entry #(
   parameter int DATA_W = 69,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);
   // Clearing keeps data but zeroes ctrl so a bubble can never write state downstream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= d_valid;
         data  <= d_data;
         ctrl  <= d_ctrl;
      end
   end
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with 2-entry skid buffer and flush-to-bubble
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = stage_data_w(EX_MEM),
   parameter int CTRL_W = stage_ctrl_w(EX_MEM)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   pipe_stage_reg_if.slave         in_if,
   pipe_stage_reg_if.master        out_if,
   output logic [1:0]              occupancy
);
   state_t            state_q;
   state_t            state_d;
   logic              in_ready;
   logic              acc;
   logic              drn;
   logic              main_load_in;
   logic              main_load_skid;
   logic              main_clr;
   logic              skid_load;
   logic              skid_clr;
   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // Ready comes only from registered state, keeping out_ready off the upstream path.
   assign in_ready = (state_q != FULL);
   assign acc      = in_if.valid & in_ready;
   assign drn      = main_valid & out_if.ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (acc) state_d = ONE;
            ONE:     if (acc && !drn) state_d = FULL;
                     else if (!acc && drn) state_d = EMPTY;
            FULL:    if (drn) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      main_clr       = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state_q)
            EMPTY: main_load_in = acc;
            ONE: begin
               skid_load    = acc & ~drn;
               main_load_in = acc & drn;
               main_clr     = ~acc & drn;
            end
            FULL: begin
               main_load_skid = drn;
               skid_clr       = drn;
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
      in_if.ready  = in_ready;
      out_if.valid = main_valid;
      out_if.data  = main_data;
      out_if.ctrl  = main_valid ? main_ctrl : '0;
      occupancy    = state_q;
   end

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .load    (main_load_in | main_load_skid),
      .clear   (main_clr),
      .d_valid (main_load_skid ? skid_valid : 1'b1),
      .d_data  (main_load_skid ? skid_data : in_if.data),
      .d_ctrl  (main_load_skid ? skid_ctrl : in_if.ctrl),
      .valid   (main_valid),
      .data    (main_data),
      .ctrl    (main_ctrl)
   );

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .load    (skid_load),
      .clear   (skid_clr),
      .d_valid (1'b1),
      .d_data  (in_if.data),
      .d_ctrl  (in_if.ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
   );
endmodule
